// File: rtl/buf_engine.sv
// Byte buffer engine: fills a DEPTH-byte buffer from the UART receiver and
// drains it in address order to the UART transmitter via a start/busy handshake.
module buf_engine #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_wr,
    input  logic          start_rd,
    input  logic          rxrdy,
    input  logic [7:0]    rxdw,
    input  logic          tx_busy,
    output logic          txstart,
    output logic [7:0]    txdw,
    output logic          done_wr,
    output logic          done_rd,
    output logic [2:0]    state
);

    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_ACK   = 3'd3,
        RD_WAIT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            txstart_d;
    logic [DW-1:0]   txdw_d;
    logic            done_wr_d, done_rd_d;
    logic            mem_we;
    logic [DW-1:0]   mem [DEPTH];

    // Next-state, address and registered-output values
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        txstart_d = 1'b0;
        txdw_d    = txdw;
        done_wr_d = 1'b0;
        done_rd_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                // A write request takes priority over a simultaneous read request
                if (start_wr) begin
                    addr_d  = '0;
                    state_d = WR;
                end else if (start_rd) begin
                    addr_d  = '0;
                    state_d = RD_ISSUE;
                end
            end
            WR: begin
                if (rxrdy) begin
                    mem_we = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        done_wr_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            RD_ISSUE: begin
                if (!tx_busy) begin
                    txdw_d    = mem[addr_q];
                    txstart_d = 1'b1;
                    state_d   = RD_ACK;
                end
            end
            RD_ACK: begin
                if (tx_busy) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!tx_busy) begin
                    if (addr_q == LAST_ADDR) begin
                        done_rd_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            txstart <= 1'b0;
            txdw    <= '0;
            done_wr <= 1'b0;
            done_rd <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            txstart <= txstart_d;
            txdw    <= txdw_d;
            done_wr <= done_wr_d;
            done_rd <= done_rd_d;
        end
    end

    // Buffer storage keeps its contents across reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= rxdw;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_buf_engine.sv
// Self-checking bench for buf_engine: directed scenarios plus randomized
// write/read rounds checked against a simple byte-array reference model.
module tb_buf_engine;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_wr, start_rd, rxrdy;
    logic [7:0] rxdw;
    logic       tx_busy;
    logic       txstart;
    logic [7:0] txdw;
    logic       done_wr, done_rd;
    logic [2:0] state;

    buf_engine #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start_wr(start_wr), .start_rd(start_rd),
        .rxrdy(rxrdy), .rxdw(rxdw), .tx_busy(tx_busy), .txstart(txstart),
        .txdw(txdw), .done_wr(done_wr), .done_rd(done_rd), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem_model [DEPTH];
    logic [7:0] wr_data   [DEPTH];
    logic [7:0] tx_q [$];
    int   tx_count     = 0;
    int   n_done_wr    = 0;
    int   n_done_rd    = 0;
    int   double_pulse = 0;
    logic prev_txstart = 1'b0;
    int   busy_cnt     = 0;
    int   busy_len     = 5;
    logic stall_req    = 1'b0;

    // Transmitter model: busy for busy_len cycles after each send request
    assign tx_busy = stall_req || (busy_cnt != 0);

    always @(negedge clk) begin
        if (txstart)
            busy_cnt = (busy_len == 0) ? int'($urandom_range(6, 1)) : busy_len;
        else if (busy_cnt != 0)
            busy_cnt = busy_cnt - 1;
    end

    // Output monitor: collects transmitted bytes and counts pulses
    always @(negedge clk) begin
        if (rst) begin
            if (txstart) begin
                tx_q.push_back(txdw);
                tx_count = tx_count + 1;
                if (prev_txstart) double_pulse = double_pulse + 1;
            end
            if (done_wr) n_done_wr = n_done_wr + 1;
            if (done_rd) n_done_rd = n_done_rd + 1;
        end
        prev_txstart = txstart;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input int min_idle, input int max_idle,
                            input bit inject_rd, input bit both_starts);
        int wr0 = n_done_wr;
        int tx0 = tx_count;
        start_wr = 1'b1;
        start_rd = both_starts;
        tick();
        start_wr = 1'b0;
        start_rd = 1'b0;
        check("wr_enter_state", 32'(state), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            repeat ($urandom_range(max_idle, min_idle)) tick();
            if (inject_rd && i == 3) begin
                start_rd = 1'b1;
                tick();
                start_rd = 1'b0;
                check("busy_start_ignored", 32'(state), 32'd1);
            end
            rxrdy = 1'b1;
            rxdw  = wr_data[i];
            tick();
            rxrdy = 1'b0;
            mem_model[i] = wr_data[i];
            check("done_wr_timing", 32'(done_wr), (i == int'(DEPTH) - 1) ? 32'd1 : 32'd0);
        end
        check("wr_back_to_idle", 32'(state), 32'd0);
        tick();
        check("done_wr_single", 32'(done_wr), 32'd0);
        check("done_wr_count", 32'(n_done_wr), 32'(wr0 + 1));
        repeat (4) tick();
        check("wr_no_transmit", 32'(tx_count), 32'(tx0));
    endtask

    task automatic start_read();
        tx_q.delete();
        start_rd = 1'b1;
        tick();
        start_rd = 1'b0;
        check("rd_enter_state", 32'(state), 32'd2);
    endtask

    task automatic finish_read(input int rd0);
        int k = 0;
        logic [7:0] v;
        while (!done_rd && k < 2000) begin
            tick();
            k++;
        end
        check("done_rd_seen", 32'(done_rd), 32'd1);
        check("rd_back_to_idle", 32'(state), 32'd0);
        tick();
        check("done_rd_single", 32'(done_rd), 32'd0);
        check("done_rd_count", 32'(n_done_rd), 32'(rd0 + 1));
        check("rd_byte_count", 32'(tx_q.size()), 32'(DEPTH));
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check("rd_byte_data", 32'(v), 32'(mem_model[i]));
        end
    endtask

    task automatic do_read();
        int rd0 = n_done_rd;
        start_read();
        finish_read(rd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txstart"}, 32'(txstart), 32'd0);
        check({tag, "_txdw"},    32'(txdw),    32'd0);
        check({tag, "_done_wr"}, 32'(done_wr), 32'd0);
        check({tag, "_done_rd"}, 32'(done_rd), 32'd0);
        check({tag, "_state"},   32'(state),   32'd0);
    endtask

    initial begin
        int rd0;
        int tx0;
        int k;
        rst = 1'b0;
        start_wr = 1'b0;
        start_rd = 1'b0;
        rxrdy = 1'b0;
        rxdw = 8'h00;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Write 0x10..0x17 spaced 3 cycles apart, then read back
        for (int i = 0; i < int'(DEPTH); i++) wr_data[i] = 8'(8'h10 + i);
        do_write(2, 2, 1'b0, 1'b0);
        do_read();

        // Read request during a write is ignored
        for (int i = 0; i < int'(DEPTH); i++) wr_data[i] = 8'($urandom);
        do_write(0, 3, 1'b1, 1'b0);

        // Simultaneous starts: write wins
        for (int i = 0; i < int'(DEPTH); i++) wr_data[i] = 8'($urandom);
        do_write(0, 2, 1'b0, 1'b1);
        do_read();

        // rxrdy in IDLE is ignored
        rxrdy = 1'b1;
        rxdw  = 8'hAA;
        tick();
        rxrdy = 1'b0;
        check("idle_rx_state", 32'(state), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) wr_data[i] = 8'(i);
        do_write(0, 2, 1'b0, 1'b0);
        do_read();
        check("idle_rx_first_byte", 32'(tx_q.size() > 0 ? tx_q[0] : 8'hxx), 32'h00);

        // Transmitter stall on entry to the read
        stall_req = 1'b1;
        rd0 = n_done_rd;
        tx0 = tx_count;
        start_read();
        repeat (20) tick();
        check("stall_no_txstart", 32'(tx_count), 32'(tx0));
        check("stall_state", 32'(state), 32'd2);
        stall_req = 1'b0;
        tick();
        check("stall_release_txstart", 32'(txstart), 32'd1);
        finish_read(rd0);

        // Randomized rounds with random transmitter busy time
        busy_len = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(DEPTH); i++) wr_data[i] = 8'($urandom);
            do_write(0, 3, 1'b0, 1'b0);
            do_read();
        end

        // Reset in the middle of a read
        busy_len = 4;
        rd0 = n_done_rd;
        tx0 = tx_count;
        start_read();
        k = 0;
        while (tx_count < tx0 + 3 && k < 500) begin
            tick();
            k++;
        end
        check("mid_rd_three_bytes", 32'(tx_count), 32'(tx0 + 3));
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        repeat (5) tick();
        rst = 1'b1;
        repeat (10) tick();
        check("mid_reset_no_done_rd", 32'(n_done_rd), 32'(rd0));
        do_read();

        check("txstart_single_cycle", 32'(double_pulse), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
